fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Fetch buffer: FIFO of (pc, instruction) pairs between fetch and decode.
// Optional same-cycle fall-through when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pcIn,
    input  logic [WIDTH-1:0]         instrIn,
    input  logic                     inValid,
    output logic                     inReady,
    output logic [WIDTH-1:0]         pcOut,
    output logic [WIDTH-1:0]         instrOut,
    output logic                     outValid,
    input  logic                     outReady,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic stored;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        stored  = (count != '0);
        inReady = (count < FULL);
        bypass  = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass  = !stored && inValid && !flush;
`endif
        outValid = stored || bypass;
        pcOut    = '0;
        instrOut = '0;
        if (stored) begin
            pcOut    = pc_mem[rd_ptr];
            instrOut = instr_mem[rd_ptr];
        end else if (bypass) begin
            pcOut    = pcIn;
            instrOut = instrIn;
        end
        // A fall-through entry taken by decode is never written.
        push = inValid && inReady && !(bypass && outReady);
        pop  = stored && outReady;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            pc_mem[wr_ptr]    <= pcIn;
            instr_mem[wr_ptr] <= instrIn;
        end
    end

endmodule
